forward_sub_n: RTL and testbench
================================

// Module: forward_sub_n
// PURPOSE
//  Parametrised successor to the dual-issue operand forwarding stage. It serves one issue slot.
//  It resolves NSRC source operands against NSTAGE bypass stages, each with NLANE write ports,
//  and registers the selected operands into the ID/EX boundary.
//  It also tracks operand validity across stall, flush and issue mode.
//  New relative to the fixed 2-stage block:
//  - r0 filtering
//  - a load-use stall request from per-lane data-ready flags
//  - a per-operand bypass-hit flag
// PARAMETERS
//  DATA_W  32  operand/data width
//  ADDR_W  5   register address width
//  NSRC    2   operands per instruction (1..4)
//  NSTAGE  2   bypass stages; index 0 = youngest (EX), NSTAGE-1 = oldest
//  NLANE   2   write lanes per stage; higher index = younger instruction in the same stage
// PORTS
//  clk         in   1                     clock, rising edge
//  rst         in   1                     asynchronous active-low reset
//  flush       in   1                     pipeline flush
//  stall       in   4                     stall vector; bits [1:0] = IF/ID stall
//  issue_mode  in   1                     1 = this slot issues this cycle
//  re          in   NSRC                  per-operand read enable
//  raddr       in   NSRC*ADDR_W           per-operand register address
//  rdata       in   NSRC*DATA_W           per-operand regfile data
//  imm         in   DATA_W                immediate, selected when re[k]=0
//  byp_we      in   NSTAGE*NLANE          bypass write enable; flat index s*NLANE+l
//  byp_waddr   in   NSTAGE*NLANE*ADDR_W   bypass destination address
//  byp_wdata   in   NSTAGE*NLANE*DATA_W   bypass data
//  byp_rdy     in   NSTAGE*NLANE          1 = byp_wdata valid now; 0 = e.g. load still in EX
//  opnd_o      out  NSRC*DATA_W           registered operands, masked by valid
//  fwd_hit_o   out  NSRC                  registered; 1 = operand k was taken from a bypass
//  stall_req   out  1                     combinational load-use stall request
// BEHAVIOUR
//  Reset (rst=0, async): operand regs 0, valid 0, fwd_hit_o 0, issue_mode_ff 0.
//   - opnd_o reads 0 during reset.
//   - stall_req depends on inputs only: 0 while all re=0 or all byp_rdy=1.
//  Operand select (per k, evaluated combinationally, captured at posedge, latency 1):
//   - re[k]=0 -> imm, no hit.
//   - re[k]=1 and raddr[k]=0 -> 0; r0 is never forwarded.
//   - else first match wins: stage 0..NSTAGE-1, lane NLANE-1..0, matching (byp_we & waddr==raddr[k]).
//   - no match -> rdata[k].
//  Load-use: stall_req=1 if any k with re[k]=1 and raddr[k]!=0 has byp_rdy=0 on its winning match.
//   - A ready older match does not mask an unready younger one.
//   - The operand register still captures; the consumer treats it as don't-care while stall is raised.
//  Hold: stall[1]&stall[0] -> operand regs, fwd_hit_o and issue_mode_ff keep their value.
//   - Hold overrides selection.
//  Valid (one bit per operand, updated every posedge), first true wins:
//   - flush -> 0
//   - stall[0]=1 and stall[1]=0 -> 0 (bubble)
//   - stall[1:0]=11 and issue_mode_ff -> 1
//   - ~issue_mode -> 0
//   - otherwise -> 1
//  issue_mode_ff: registered issue_mode. It freezes on hold, so the operand and mode stay paired.
//  Simultaneous flush+hold: flush wins for valid; operand regs hold.
//  opnd_o = operand reg AND replicated valid.
// CONFIGURATION
//  FWD_PERF_CNT_EN defined:
//   - adds output perf_fwd_cnt (32 bits).
//   - Each non-hold, non-flush posedge adds popcount(new hits).
//   - Saturates at 0xFFFF_FFFF; reset to 0.
//  FWD_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  (Defaults, NLANE=2, NSTAGE=2)
//  1. rst low mid-run with opnd regs = 0x1234 -> opnd_o=0 at once, fwd_hit_o=0, valid=0 after release.
//  2. re=01, raddr0=5; stage0 lane0 and lane1 both write r5 (0xA, 0xB); stage1 lane1 writes 0xC
//     -> opnd_o[0]=0xB next cycle, fwd_hit_o[0]=1.
//  3. raddr0=0, stage0 lane1 writes r0=0xFF -> opnd_o[0]=0, fwd_hit_o[0]=0.
//  4. Stage0 lane0 writes r7 with byp_rdy=0, stage1 writes r7 rdy=1, raddr1=7 -> stall_req=1 same cycle;
//     next cycle byp_rdy=1 -> stall_req=0.
//  5. issue_mode=1, then stall=0011 for 3 cycles with forwarding inputs changed
//     -> opnd_o unchanged, valid=1 throughout; stall=0001 -> valid=0 next cycle.
//  6. flush together with stall=0011 -> valid=0; with FWD_PERF_CNT_EN, counter unchanged that cycle.

Source files
------------

// File: rtl/forward_sub_n.sv
// forward_sub_n: resolves NSRC operands against NSTAGE x NLANE bypass ports, raises the load-use stall, registers ID/EX operands.
// Optional FWD_PERF_CNT_EN adds perf_fwd_cnt, a saturating count of operands taken from a bypass.
module forward_sub_n #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NSRC   = 2,
   parameter int NSTAGE = 2,
   parameter int NLANE  = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic [3:0]                       stall,
   input  logic                             issue_mode,
   input  logic [NSRC-1:0]                  re,
   input  logic [NSRC*ADDR_W-1:0]           raddr,
   input  logic [NSRC*DATA_W-1:0]           rdata,
   input  logic [DATA_W-1:0]                imm,
   input  logic [NSTAGE*NLANE-1:0]          byp_we,
   input  logic [NSTAGE*NLANE*ADDR_W-1:0]   byp_waddr,
   input  logic [NSTAGE*NLANE*DATA_W-1:0]   byp_wdata,
   input  logic [NSTAGE*NLANE-1:0]          byp_rdy,
   output logic [NSRC*DATA_W-1:0]           opnd_o,
   output logic [NSRC-1:0]                  fwd_hit_o,
   output logic                             stall_req
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]                      perf_fwd_cnt
`endif
);

   logic [NSRC*DATA_W-1:0] w_sel_data;
   logic [NSRC-1:0]        w_sel_hit;
   logic [NSRC-1:0]        w_sel_unrdy;
   logic                   w_hold;
   logic                   w_valid_nxt;
   logic                   w_unused_stall;

   logic [NSRC*DATA_W-1:0] r_opnd;
   logic [NSRC-1:0]        r_hit;
   logic [NSRC-1:0]        r_valid;
   logic                   r_issue_ff;

   assign w_hold         = stall[1] & stall[0];
   assign w_unused_stall = ^stall[3:2];

   // Scan from lowest to highest priority so the last match (youngest stage, youngest lane) wins.
   always_comb begin
      w_sel_data  = rdata;
      w_sel_hit   = '0;
      w_sel_unrdy = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (!re[k]) begin
            w_sel_data[k*DATA_W +: DATA_W] = imm;
         end else if (raddr[k*ADDR_W +: ADDR_W] == '0) begin
            w_sel_data[k*DATA_W +: DATA_W] = '0;
         end else begin
            for (int s = NSTAGE-1; s >= 0; s--) begin
               for (int l = 0; l < NLANE; l++) begin
                  if (byp_we[s*NLANE+l] &&
                      (byp_waddr[(s*NLANE+l)*ADDR_W +: ADDR_W] == raddr[k*ADDR_W +: ADDR_W])) begin
                     w_sel_data[k*DATA_W +: DATA_W] = byp_wdata[(s*NLANE+l)*DATA_W +: DATA_W];
                     w_sel_hit[k]   = 1'b1;
                     w_sel_unrdy[k] = ~byp_rdy[s*NLANE+l];
                  end
               end
            end
         end
      end
   end

   assign stall_req = |w_sel_unrdy;

   always_comb begin
      if (flush)
         w_valid_nxt = 1'b0;
      else if (stall[0] && !stall[1])
         w_valid_nxt = 1'b0;
      else if (w_hold && r_issue_ff)
         w_valid_nxt = 1'b1;
      else if (!issue_mode)
         w_valid_nxt = 1'b0;
      else
         w_valid_nxt = 1'b1;
   end

   // Operand, hit and mode freeze together on hold so a held operand keeps its issue context.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_opnd     <= '0;
         r_hit      <= '0;
         r_valid    <= '0;
         r_issue_ff <= 1'b0;
      end else begin
         if (!w_hold) begin
            r_opnd     <= w_sel_data;
            r_hit      <= w_sel_hit;
            r_issue_ff <= issue_mode;
         end
         r_valid <= {NSRC{w_valid_nxt}};
      end
   end

   always_comb begin
      opnd_o = '0;
      for (int k = 0; k < NSRC; k++)
         opnd_o[k*DATA_W +: DATA_W] = r_opnd[k*DATA_W +: DATA_W] & {DATA_W{r_valid[k]}};
   end

   assign fwd_hit_o = r_hit;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] r_cnt;
   logic [32:0] w_cnt_sum;

   always_comb begin
      w_cnt_sum = {1'b0, r_cnt};
      for (int k = 0; k < NSRC; k++)
         w_cnt_sum = w_cnt_sum + 33'(w_sel_hit[k]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_cnt <= '0;
      else if (!w_hold && !flush)
         r_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
   end

   assign perf_fwd_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_forward_sub_n.sv
// Directed scoreboard bench for forward_sub_n at default parameters (2 operands, 2 stages, 2 lanes).
module tb_forward_sub_n;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NSRC   = 2;
   localparam int NSTAGE = 2;
   localparam int NLANE  = 2;

   logic                           clk = 1'b0;
   logic                           rst;
   logic                           flush;
   logic [3:0]                     stall;
   logic                           issue_mode;
   logic [NSRC-1:0]                re;
   logic [NSRC*ADDR_W-1:0]         raddr;
   logic [NSRC*DATA_W-1:0]         rdata;
   logic [DATA_W-1:0]              imm;
   logic [NSTAGE*NLANE-1:0]        byp_we;
   logic [NSTAGE*NLANE*ADDR_W-1:0] byp_waddr;
   logic [NSTAGE*NLANE*DATA_W-1:0] byp_wdata;
   logic [NSTAGE*NLANE-1:0]        byp_rdy;
   logic [NSRC*DATA_W-1:0]         opnd_o;
   logic [NSRC-1:0]                fwd_hit_o;
   logic                           stall_req;
`ifdef FWD_PERF_CNT_EN
   logic [31:0]                    perf_fwd_cnt;
`endif

   forward_sub_n #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC), .NSTAGE(NSTAGE), .NLANE(NLANE)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .issue_mode(issue_mode),
      .re(re), .raddr(raddr), .rdata(rdata), .imm(imm),
      .byp_we(byp_we), .byp_waddr(byp_waddr), .byp_wdata(byp_wdata), .byp_rdy(byp_rdy),
      .opnd_o(opnd_o), .fwd_hit_o(fwd_hit_o), .stall_req(stall_req)
`ifdef FWD_PERF_CNT_EN
      , .perf_fwd_cnt(perf_fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] opnd;
      logic [1:0]  hit;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_cnt  = 0;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] o1, input logic [31:0] o0,
                       input logic [1:0] hit, input int add);
      exp_t e;
      exp_cnt = exp_cnt + 32'(add);
      e.tag  = tag;
      e.opnd = {o1, o0};
      e.hit  = hit;
      e.cnt  = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() > 0) else begin
         failures++;
         $error("FAIL sb_empty got=0 exp=1");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_vec({e.tag, "_opnd"}, opnd_o, e.opnd);
         check_vec({e.tag, "_hit"}, 64'(fwd_hit_o), 64'(e.hit));
`ifdef FWD_PERF_CNT_EN
         check_vec({e.tag, "_cnt"}, 64'(perf_fwd_cnt), 64'(e.cnt));
`endif
      end
   endtask

   task automatic clr_byp();
      byp_we    = '0;
      byp_waddr = '0;
      byp_wdata = '0;
      byp_rdy   = '1;
   endtask

   task automatic set_byp(input int s, input int l, input logic [4:0] a, input logic [31:0] d, input logic rdy);
      int idx;
      idx = s*NLANE + l;
      byp_we[idx]                     = 1'b1;
      byp_waddr[idx*ADDR_W +: ADDR_W] = a;
      byp_wdata[idx*DATA_W +: DATA_W] = d;
      byp_rdy[idx]                    = rdy;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; stall = 4'b0000; issue_mode = 1'b0;
      re = '0; raddr = '0; rdata = '0; imm = '0;
      clr_byp();
      set_byp(0, 0, 5'd1, 32'h1, 1'b0);
      byp_rdy = '0;
      #7;
      check_vec("rst_opnd", opnd_o, 64'h0);
      check_vec("rst_hit", 64'(fwd_hit_o), 64'h0);
      check_vec("rst_stall_req", 64'(stall_req), 64'h0);
      clr_byp();
      @(negedge clk);
      rst = 1'b1;

      // plain regfile read
      issue_mode = 1'b1; re = 2'b11; raddr = {5'd4, 5'd3}; rdata = {32'h44, 32'h33};
      push("a_rf", 32'h44, 32'h33, 2'b00, 0);
      tick();

      // youngest lane of youngest stage wins; re[1]=0 selects imm
      re = 2'b01; raddr = {5'd5, 5'd5}; imm = 32'h99;
      set_byp(0, 0, 5'd5, 32'hA, 1'b1);
      set_byp(0, 1, 5'd5, 32'hB, 1'b1);
      set_byp(1, 1, 5'd5, 32'hC, 1'b1);
      #1 check_vec("t2_stall_req", 64'(stall_req), 64'h0);
      push("t2_lane", 32'h99, 32'hB, 2'b01, 1);
      tick();

      clr_byp();
      re = 2'b11; raddr = {5'd8, 5'd6}; rdata = {32'h88, 32'h66};
      set_byp(1, 0, 5'd6, 32'h60, 1'b1);
      set_byp(1, 1, 5'd6, 32'h61, 1'b1);
      push("c_s1", 32'h88, 32'h61, 2'b01, 1);
      tick();

      clr_byp();
      raddr = {5'd6, 5'd6};
      set_byp(0, 0, 5'd6, 32'h50, 1'b1);
      set_byp(1, 1, 5'd6, 32'h61, 1'b1);
      push("c2_stage", 32'h50, 32'h50, 2'b11, 2);
      tick();

      // r0 is never forwarded and never stalls
      clr_byp();
      raddr = {5'd9, 5'd0}; rdata = {32'h900, 32'h111};
      set_byp(0, 1, 5'd0, 32'hFF, 1'b0);
      #1 check_vec("t3_r0_stall", 64'(stall_req), 64'h0);
      push("t3_r0", 32'h900, 32'h0, 2'b00, 0);
      tick();

      // load-use
      clr_byp();
      re = 2'b10; raddr = {5'd7, 5'd0}; imm = 32'h77;
      set_byp(0, 0, 5'd7, 32'h70, 1'b0);
      set_byp(1, 0, 5'd7, 32'h71, 1'b1);
      #1 check_vec("t4_lu", 64'(stall_req), 64'h1);
      push("t4_cap", 32'h70, 32'h77, 2'b10, 1);
      tick();
      byp_rdy[0] = 1'b1;
      #1 check_vec("t4_rdy", 64'(stall_req), 64'h0);
      push("t4_rdy", 32'h70, 32'h77, 2'b10, 1);
      tick();
      byp_rdy[2] = 1'b0;
      #1 check_vec("older_unrdy_masked", 64'(stall_req), 64'h0);
      set_byp(0, 1, 5'd7, 32'h7B, 1'b0);
      #1 check_vec("lane_unrdy", 64'(stall_req), 64'h1);
      push("e3", 32'h7B, 32'h77, 2'b10, 1);
      tick();

      // hold with issue_mode_ff=1 keeps operands and valid, then bubble
      clr_byp();
      re = 2'b11; raddr = {5'd4, 5'd3}; rdata = {32'h44, 32'h33};
      push("f_pre", 32'h44, 32'h33, 2'b00, 0);
      tick();
      stall = 4'b0011; issue_mode = 1'b0;
      set_byp(0, 0, 5'd3, 32'hDEAD, 1'b1);
      rdata = {32'h4444, 32'h3333};
      for (int i = 0; i < 3; i++) begin
         push("t5_hold", 32'h44, 32'h33, 2'b00, 0);
         tick();
         rdata = rdata + 64'h1;
      end
      stall = 4'b0001;
      push("t5_bubble", 32'h0, 32'h0, 2'b01, 1);
      tick();

      // flush during hold: valid drops but operands hold
      stall = 4'b0000; issue_mode = 1'b1; clr_byp();
      rdata = {32'h44, 32'h33};
      push("g_pre", 32'h44, 32'h33, 2'b00, 0);
      tick();
      flush = 1'b1; stall = 4'b0011;
      set_byp(0, 0, 5'd4, 32'hBEEF, 1'b1);
      push("t6_flush", 32'h0, 32'h0, 2'b00, 0);
      tick();
      flush = 1'b0;
      push("t6_after", 32'h44, 32'h33, 2'b00, 0);
      tick();

      stall = 4'b0000; issue_mode = 1'b0;
      push("h_noissue", 32'h0, 32'h0, 2'b10, 1);
      tick();

      stall = 4'b0010; issue_mode = 1'b1; clr_byp();
      rdata = {32'h22, 32'h11};
      push("i_st1only", 32'h22, 32'h11, 2'b00, 0);
      tick();
      stall = 4'b1100; rdata = {32'h2, 32'h1};
      push("i_upper", 32'h2, 32'h1, 2'b00, 0);
      tick();

      stall = 4'b0000; flush = 1'b1;
      set_byp(1, 0, 5'd3, 32'h5A, 1'b1);
      push("flush_only", 32'h0, 32'h0, 2'b01, 0);
      tick();

      // asynchronous reset mid-run
      flush = 1'b0; clr_byp();
      re = 2'b01; raddr = {5'd0, 5'd2}; rdata = {32'h0, 32'h1234}; imm = 32'h0;
      push("t1_pre", 32'h0, 32'h1234, 2'b00, 0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      #1;
      check_vec("t1_rst_async", opnd_o, 64'h0);
      check_vec("t1_rst_hit", 64'(fwd_hit_o), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      #1 check_vec("t1_rel", opnd_o, 64'h0);
      push("t1_post", 32'h0, 32'h1234, 2'b00, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
